// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : phase_sequencer
// Purpose  : Round-robin phase controller. It enables NUM_PHASES datapath
//            modules (Y-matrix update, write, integrate, ...) one at a time
//            in a fixed cyclic order. It advances on the done pulse of the
//            active phase, counts full cycles and reports completion and
//            protocol errors. It owns the bus-control enables.
// Revision : 1.0 - initial release
//
// Optional build macro:
//   PHASE_WATCHDOG_EN - per-phase watchdog. If a phase runs in_timeoutLimit
//                       cycles without an advance, op_timeout is set and the
//                       sequence is abandoned. Without the macro op_timeout
//                       is tied low and in_timeoutLimit is ignored.
//
// Ports:
//   clock           in   1           system clock
//   reset           in   1           synchronous reset, active low
//   soft_rst        in   1           synchronous soft reset; keeps error flags
//   in_start        in   1           start pulse, accepted only when idle
//   in_numIter      in   ITER_W      full cycles to run (0 = forever)
//   in_doneFlags    in   NUM_PHASES  per-phase done pulses
//   in_timeoutLimit in   TO_W        watchdog limit in cycles (0 = off)
//   op_phaseEnable  out  NUM_PHASES  one-hot phase enables
//   op_phaseIdx     out  IDX_W       index of the active phase
//   op_iterCount    out  ITER_W      completed full cycles
//   op_busy         out  1           sequence running
//   op_seqDone      out  1           one-cycle completion pulse
//   op_protocolErr  out  1           sticky unexpected-done flag
//   op_timeout      out  1           sticky watchdog flag
// ============================================================================
module phase_sequencer #(
  parameter int NUM_PHASES  = 3,
  parameter int START_PHASE = 0,
  parameter int ITER_W      = 8,
  parameter int TO_W        = 16,
  parameter int IDX_W       = $clog2(NUM_PHASES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  soft_rst,
  input  logic                  in_start,
  input  logic [ITER_W-1:0]     in_numIter,
  input  logic [NUM_PHASES-1:0] in_doneFlags,
  input  logic [TO_W-1:0]       in_timeoutLimit,
  output logic [NUM_PHASES-1:0] op_phaseEnable,
  output logic [IDX_W-1:0]      op_phaseIdx,
  output logic [ITER_W-1:0]     op_iterCount,
  output logic                  op_busy,
  output logic                  op_seqDone,
  output logic                  op_protocolErr,
  output logic                  op_timeout
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_run    = 2'd1;
  localparam logic [1:0] c_st_finish = 2'd2;

  localparam logic [IDX_W-1:0]      c_start_idx = IDX_W'(START_PHASE);
  localparam logic [IDX_W-1:0]      c_last_idx  = IDX_W'(NUM_PHASES - 1);
  localparam logic [NUM_PHASES-1:0] c_one       = NUM_PHASES'(1);

  // --------------------------------------------------------------------------
  // State and registers
  // --------------------------------------------------------------------------
  logic [1:0]                  state_q,    state_d;
  logic [IDX_W-1:0]            idx_q,      idx_d;
  logic [ITER_W-1:0]           iter_q,     iter_d;
  logic [ITER_W-1:0]           limit_q,    limit_d;
  logic [NUM_PHASES-1:0]       en_q,       en_d;
  logic                        busy_q,     busy_d;
  logic                        seq_q,      seq_d;
  logic                        perr_q,     perr_d;
  logic                        tout_q,     tout_d;
  // Phase that was active in the previous cycle, valid only right after an
  // advance; its done bit is forgiven for one cycle (two-cycle done pulses).
  logic [IDX_W-1:0]            prev_idx_q, prev_idx_d;
  logic                        mask_vld_q, mask_vld_d;
  // Per-phase count of consecutive high done cycles, saturating at 2.
  logic [NUM_PHASES-1:0][1:0]  hold_q,     hold_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [NUM_PHASES-1:0]       w_active_oh;
  logic [NUM_PHASES-1:0]       w_mask_oh;
  logic [NUM_PHASES-1:0]       w_long;
  logic [NUM_PHASES-1:0][1:0]  w_hold_upd;
  logic                        w_advance;
  logic                        w_stray;
  logic                        w_wrap;
  logic                        w_finish;
  logic                        w_wd_expire;
  logic [IDX_W-1:0]            w_idx_next;
  logic [ITER_W-1:0]           w_iter_inc;

  assign w_active_oh = c_one << idx_q;
  assign w_mask_oh   = mask_vld_q ? (c_one << prev_idx_q) : '0;
  assign w_advance   = (state_q == c_st_run) && (|(in_doneFlags & w_active_oh));
  // Any done bit that is neither the active phase nor the forgiven one.
  assign w_stray     = |(in_doneFlags & ~w_active_oh & ~w_mask_oh);
  assign w_idx_next  = (idx_q == c_last_idx) ? '0 : idx_q + IDX_W'(1);
  assign w_wrap      = w_advance && (idx_q == c_last_idx);
  assign w_iter_inc  = iter_q + ITER_W'(1);
  assign w_finish    = w_wrap && (limit_q != '0) && (w_iter_inc == limit_q);

  generate
    for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_hold
      // A third consecutive high cycle on any done bit is a protocol error.
      assign w_long[gi]     = in_doneFlags[gi] && (hold_q[gi] == 2'd2);
      assign w_hold_upd[gi] = !in_doneFlags[gi]     ? 2'd0 :
                              (hold_q[gi] == 2'd2)  ? 2'd2 :
                                                      hold_q[gi] + 2'd1;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Watchdog
  // --------------------------------------------------------------------------
`ifdef PHASE_WATCHDOG_EN
  logic [TO_W-1:0] wd_q, wd_d;

  // The counter holds the number of RUN cycles spent in the current phase
  // minus one, so reaching limit-1 with no advance means limit cycles elapsed.
  assign w_wd_expire = (state_q == c_st_run) && !w_advance &&
                       (in_timeoutLimit != '0) &&
                       (wd_q == in_timeoutLimit - TO_W'(1));

  always_comb begin
    wd_d = wd_q;
    if (soft_rst) begin
      wd_d = '0;
    end else if ((state_q == c_st_idle) && in_start) begin
      wd_d = '0;
    end else if (state_q == c_st_run) begin
      wd_d = w_advance ? '0 : wd_q + TO_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic w_unused_to;

  assign w_wd_expire = 1'b0;
  assign w_unused_to = ^in_timeoutLimit;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= c_st_idle;
      idx_q      <= c_start_idx;
      iter_q     <= '0;
      limit_q    <= '0;
      en_q       <= '0;
      busy_q     <= 1'b0;
      seq_q      <= 1'b0;
      perr_q     <= 1'b0;
      tout_q     <= 1'b0;
      prev_idx_q <= c_start_idx;
      mask_vld_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      iter_q     <= iter_d;
      limit_q    <= limit_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      seq_q      <= seq_d;
      perr_q     <= perr_d;
      tout_q     <= tout_d;
      prev_idx_q <= prev_idx_d;
      mask_vld_q <= mask_vld_d;
      hold_q     <= hold_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    iter_d     = iter_q;
    limit_d    = limit_q;
    perr_d     = perr_q;
    tout_d     = tout_q;
    prev_idx_d = idx_q;
    mask_vld_d = 1'b0;
    hold_d     = '0;

    if (soft_rst) begin
      // Error flags deliberately survive a soft reset.
      state_d = c_st_idle;
      idx_d   = c_start_idx;
      iter_d  = '0;
    end else begin
      case (state_q)
        c_st_idle: begin
          if (in_start) begin
            state_d = c_st_run;
            idx_d   = c_start_idx;
            iter_d  = '0;
            limit_d = in_numIter;
          end
        end

        c_st_run: begin
          hold_d = w_hold_upd;
          if (w_stray || (|w_long)) begin
            perr_d = 1'b1;
          end
          if (w_advance) begin
            idx_d      = w_idx_next;
            mask_vld_d = 1'b1;
            if (w_wrap) begin
              iter_d = w_iter_inc;
              if (w_finish) begin
                state_d = c_st_finish;
              end
            end
          end else if (w_wd_expire) begin
            // Abandon the sequence; no completion pulse is issued.
            tout_d  = 1'b1;
            state_d = c_st_idle;
          end
        end

        c_st_finish: begin
          state_d = c_st_idle;
        end

        default: begin
          state_d = c_st_idle;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output logic (decoded from the next state so outputs come from flops)
  // --------------------------------------------------------------------------
  always_comb begin
    en_d   = '0;
    busy_d = 1'b0;
    seq_d  = 1'b0;
    case (state_d)
      c_st_run: begin
        en_d   = c_one << idx_d;
        busy_d = 1'b1;
      end
      c_st_finish: begin
        seq_d = 1'b1;
      end
      default: begin
        en_d = '0;
      end
    endcase
  end

  assign op_phaseEnable = en_q;
  assign op_phaseIdx    = idx_q;
  assign op_iterCount   = iter_q;
  assign op_busy        = busy_q;
  assign op_seqDone     = seq_q;
  assign op_protocolErr = perr_q;
  assign op_timeout     = tout_q;

endmodule
`default_nettype wire

// File: tb/tb_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_sequencer
// Purpose  : Self-checking bench for phase_sequencer (NUM_PHASES = 3).
//            Directed scenarios plus a randomized run compared cycle by cycle
//            against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phase_sequencer;
  localparam int N     = 3;
  localparam int START = 0;
  localparam int IW    = 8;
  localparam int TW    = 16;
  localparam int XW    = $clog2(N);
  localparam int VW    = N + XW + IW + 4;

  localparam logic [N-1:0] SEQ_EN [6] = '{3'b010, 3'b100, 3'b001,
                                           3'b010, 3'b100, 3'b000};

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          soft_rst = 1'b0;
  logic          in_start = 1'b0;
  logic [IW-1:0] in_numIter = '0;
  logic [N-1:0]  in_doneFlags = '0;
  logic [TW-1:0] in_timeoutLimit = '0;
  logic [N-1:0]  op_phaseEnable;
  logic [XW-1:0] op_phaseIdx;
  logic [IW-1:0] op_iterCount;
  logic          op_busy;
  logic          op_seqDone;
  logic          op_protocolErr;
  logic          op_timeout;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  phase_sequencer #(
    .NUM_PHASES (N),
    .START_PHASE(START),
    .ITER_W     (IW),
    .TO_W       (TW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .soft_rst       (soft_rst),
    .in_start       (in_start),
    .in_numIter     (in_numIter),
    .in_doneFlags   (in_doneFlags),
    .in_timeoutLimit(in_timeoutLimit),
    .op_phaseEnable (op_phaseEnable),
    .op_phaseIdx    (op_phaseIdx),
    .op_iterCount   (op_iterCount),
    .op_busy        (op_busy),
    .op_seqDone     (op_seqDone),
    .op_protocolErr (op_protocolErr),
    .op_timeout     (op_timeout)
  );

  always #5 clock = ~clock;

  // --------------------------------------------------------------------------
  // Reference model: 0 = idle, 1 = run, 2 = finish
  // --------------------------------------------------------------------------
  int m_state, m_idx, m_iter, m_limit, m_prev, m_wd;
  int m_run [N];
  bit m_err, m_tout;

  task automatic model_reset();
    m_state = 0; m_idx = START; m_iter = 0; m_limit = 0; m_prev = -1; m_wd = 0;
    m_err = 0; m_tout = 0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endtask

  task automatic model_edge(input logic st, input logic [N-1:0] d, input logic sr);
    int old_prev;
    old_prev = m_prev;
    m_prev   = -1;
    if (sr) begin
      m_state = 0; m_idx = START; m_iter = 0; m_wd = 0;
    end else if (m_state == 0) begin
      if (st) begin
        m_state = 1; m_idx = START; m_iter = 0; m_limit = int'(in_numIter); m_wd = 0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
      end
    end else if (m_state == 1) begin
      for (int i = 0; i < N; i++) begin
        if (d[i] && i != m_idx && i != old_prev) m_err = 1;
        if (d[i] && m_run[i] >= 2) m_err = 1;
        m_run[i] = d[i] ? m_run[i] + 1 : 0;
      end
      if (d[m_idx]) begin
        m_prev = m_idx;
        m_idx  = (m_idx + 1) % N;
        m_wd   = 0;
        if (m_idx == 0) begin
          m_iter = (m_iter + 1) % (1 << IW);
          if (m_limit != 0 && m_iter == m_limit) m_state = 2;
        end
      end else begin
`ifdef PHASE_WATCHDOG_EN
        if (in_timeoutLimit != 0 && m_wd == int'(in_timeoutLimit) - 1) begin
          m_tout = 1; m_state = 0;
        end else begin
          m_wd = m_wd + 1;
        end
`endif
      end
    end else begin
      m_state = 0;
    end
  endtask

  // One clock with the given inputs; the model advances at the same edge.
  task automatic step(input logic st, input logic [N-1:0] d, input logic sr);
    in_start = st; in_doneFlags = d; soft_rst = sr;
    @(posedge clock);
    model_edge(st, d, sr);
    #1;
    in_start = 1'b0; in_doneFlags = '0; soft_rst = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; in_start = 1'b0; in_doneFlags = '0; soft_rst = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    logic [VW-1:0] got, exp;
    do_reset();
    got = {op_phaseEnable, op_phaseIdx, op_iterCount, op_busy, op_seqDone, op_protocolErr, op_timeout};
    exp = {N'(0), XW'(START), IW'(0), 4'b0000};
    chk_cnt++;
    if (got !== exp) $display("FAIL reset_values: got %h want %h", got, exp);
    else pass_cnt++;
    in_numIter = 8'd2;
    step(1'b1, '0, 1'b0);
    chk_cnt++;
    if (op_phaseEnable !== 3'b001) $display("FAIL start_enable: got %b want 001", op_phaseEnable);
    else pass_cnt++;
    chk_cnt++;
    if (op_busy !== 1'b1) $display("FAIL start_busy: got %b want 1", op_busy);
    else pass_cnt++;
  endtask

  // Continues from test_reset: two full cycles, then completion.
  task automatic test_sequence();
    logic [N-1:0] d;
    d = 3'b001;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, d, 1'b0);
      chk_cnt++;
      if (op_phaseEnable !== SEQ_EN[i]) $display("FAIL seq_enable[%0d]: got %b want %b", i, op_phaseEnable, SEQ_EN[i]);
      else pass_cnt++;
      chk_cnt++;
      if (op_seqDone !== (i == 5)) $display("FAIL seq_done[%0d]: got %b want %b", i, op_seqDone, (i == 5));
      else pass_cnt++;
      if (i == 2 || i == 5) begin
        chk_cnt++;
        if (op_iterCount !== IW'(i == 2 ? 1 : 2)) $display("FAIL seq_iter[%0d]: got %0d want %0d", i, op_iterCount, (i == 2 ? 1 : 2));
        else pass_cnt++;
      end
      d = SEQ_EN[i];
    end
    step(1'b0, '0, 1'b0);
    chk_cnt++;
    if ({op_seqDone, op_busy, op_iterCount} !== {2'b00, IW'(2)})
      $display("FAIL seq_idle: got done=%b busy=%b iter=%0d want 0 0 2", op_seqDone, op_busy, op_iterCount);
    else pass_cnt++;
  endtask

  task automatic test_protocol_err();
    do_reset();
    in_numIter = 8'd2;
    step(1'b1, '0, 1'b0);
    step(1'b0, 3'b100, 1'b0);
    chk_cnt++;
    if ({op_protocolErr, op_phaseEnable} !== 4'b1_001)
      $display("FAIL perr_stray: got err=%b en=%b want 1 001", op_protocolErr, op_phaseEnable);
    else pass_cnt++;
    step(1'b0, '0, 1'b1);
    chk_cnt++;
    if ({op_protocolErr, op_busy, op_phaseEnable} !== 5'b1_0_000)
      $display("FAIL perr_softrst: got err=%b busy=%b en=%b want 1 0 000", op_protocolErr, op_busy, op_phaseEnable);
    else pass_cnt++;
    do_reset();
    chk_cnt++;
    if (op_protocolErr !== 1'b0) $display("FAIL perr_hardrst: got %b want 0", op_protocolErr);
    else pass_cnt++;
  endtask

  task automatic test_done_hold();
    for (int len = 2; len <= 3; len++) begin
      do_reset();
      in_numIter = 8'd2;
      step(1'b1, '0, 1'b0);
      step(1'b0, 3'b001, 1'b0);
      repeat (len) step(1'b0, 3'b010, 1'b0);
      chk_cnt++;
      if ({op_phaseIdx, op_phaseEnable, op_protocolErr} !== {XW'(2), 3'b100, (len == 3)})
        $display("FAIL hold%0d: got idx=%0d en=%b err=%b want 2 100 %0d", len, op_phaseIdx, op_phaseEnable, op_protocolErr, (len == 3));
      else pass_cnt++;
    end
  endtask

  task automatic test_forever();
    bit seq_seen;
    do_reset();
    seq_seen = 0;
    in_numIter = 8'd0;
    step(1'b1, '0, 1'b0);
    for (int c = 1; c <= 300; c++) begin
      for (int p = 0; p < N; p++) begin
        step(1'b0, 3'b001 << p, 1'b0);
        if (op_seqDone) seq_seen = 1;
      end
      chk_cnt++;
      if (op_iterCount !== IW'(c % 256)) $display("FAIL forever_iter[%0d]: got %0d want %0d", c, op_iterCount, c % 256);
      else pass_cnt++;
    end
    chk_cnt++;
    if ({seq_seen, op_busy, op_protocolErr} !== 3'b010)
      $display("FAIL forever_state: got seen=%b busy=%b err=%b want 0 1 0", seq_seen, op_busy, op_protocolErr);
    else pass_cnt++;
    step(1'b0, '0, 1'b1);
  endtask

  task automatic test_watchdog();
    do_reset();
    in_timeoutLimit = 16'd10;
    in_numIter = 8'd1;
    step(1'b1, '0, 1'b0);
    repeat (9) step(1'b0, '0, 1'b0);
    chk_cnt++;
    if ({op_timeout, op_busy} !== 2'b01) $display("FAIL wd_before: got tout=%b busy=%b want 0 1", op_timeout, op_busy);
    else pass_cnt++;
    step(1'b0, '0, 1'b0);
    chk_cnt++;
`ifdef PHASE_WATCHDOG_EN
    if ({op_timeout, op_busy, op_phaseEnable, op_seqDone} !== 6'b1_0_000_0)
      $display("FAIL wd_expire: got tout=%b busy=%b en=%b done=%b want 1 0 000 0", op_timeout, op_busy, op_phaseEnable, op_seqDone);
    else pass_cnt++;
`else
    if ({op_timeout, op_busy} !== 2'b01) $display("FAIL wd_disabled: got tout=%b busy=%b want 0 1", op_timeout, op_busy);
    else pass_cnt++;
`endif
    in_timeoutLimit = '0;
    step(1'b0, '0, 1'b1);
  endtask

  task automatic test_random();
    logic [VW-1:0] got, exp;
    logic [N-1:0]  d, last_d;
    logic          st, sr;
    int            r, r2, nfail;
    do_reset();
    last_d = '0;
    nfail  = 0;
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 199);
      if (r == 0) begin
        do_reset();
      end else begin
        in_numIter = IW'($urandom_range(0, 3));
        st = ($urandom_range(0, 7) == 0);
        sr = (r == 1);
        r2 = $urandom_range(0, 19);
        if (r2 < 9)       d = (m_state == 1) ? N'(1 << m_idx) : '0;
        else if (r2 < 13) d = last_d;
        else if (r2 == 13) d = N'($urandom);
        else              d = '0;
        last_d = d;
        step(st, d, sr);
      end
      got = {op_phaseEnable, op_phaseIdx, op_iterCount, op_busy, op_seqDone, op_protocolErr, op_timeout};
      exp = {(m_state == 1) ? N'(1 << m_idx) : N'(0), XW'(m_idx), IW'(m_iter),
             (m_state == 1), (m_state == 2), m_err, m_tout};
      chk_cnt++;
      if (got !== exp) begin
        nfail++;
        if (nfail <= 10) $display("FAIL random[%0d]: got %h want %h", k, got, exp);
      end else begin
        pass_cnt++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequence();
    test_protocol_err();
    test_done_hold();
    test_forever();
    test_watchdog();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
